// File: rtl/multiplicador_defines.sv
// Shared definitions for the multiplier family and the board RAM controller.
package multiplicador_defines;

    localparam int MULT_ST_W = 3;

    // Multiplier controller states; codes 5 to 7 are unused and fall back to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_STEP = 3'd2,
        ST_SIGN = 3'd3,
        ST_END  = 3'd4
    } estado_mult_t;

    // Board RAM controller states, kept here so both controllers share one package.
    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_READ  = 2'd1,
        RAM_WRITE = 2'd2
    } estado_ram_t;

endpackage

// File: rtl/controlador_mult_param.sv
// Sequencing FSM and step counter for the parametrised shift-and-add multiplier.
module controlador_mult_param
    import multiplicador_defines::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     strt_cmpt_i,
    output estado_mult_t             state_o,
    output logic                     capture_en_o,
    output logic                     load_en_o,
    output logic                     step_en_o,
    output logic                     sign_en_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(WIDTH)-1:0] step_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    estado_mult_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and step counter registers; reset aborts any computation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and datapath enables; start is only looked at in IDLE and END.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_en_o = 1'b0;
        load_en_o    = 1'b0;
        step_en_o    = 1'b0;
        sign_en_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strt_cmpt_i) begin
                    capture_en_o = 1'b1;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en_o = 1'b1;
                cnt_d     = '0;
                state_d   = ST_STEP;
            end
            ST_STEP: begin
                step_en_o = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = ST_SIGN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SIGN: begin
                sign_en_o = 1'b1;
                state_d   = ST_END;
            end
            ST_END: begin
                if (!strt_cmpt_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state_o = state_q;
    assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_END);
    assign done_o  = (state_q == ST_END);
    assign step_o  = (state_q == ST_STEP) ? cnt_q : '0;

endmodule

// File: rtl/multiplicador_seq_param.sv
// Parametrised sequential shift-and-add multiplier with signed/unsigned mode.
module multiplicador_seq_param
    import multiplicador_defines::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     strt_cmpt_i,
    input  logic                     mode_i,
    input  logic [WIDTH-1:0]         a_i,
    input  logic [WIDTH-1:0]         b_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*WIDTH-1:0]       prod_o,
    output logic [MULT_ST_W-1:0]     state_o,
    output logic [$clog2(WIDTH)-1:0] step_o
);

    localparam int PW = 2 * WIDTH;

    estado_mult_t ctrlState;
    logic         captureEn, loadEn, stepEn, signEn;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH:0]   partialSum;
    logic [PW-1:0]    rawProd;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic signedMode);
        if (signedMode && v[WIDTH-1]) begin
            return -v;
        end
        return v;
    endfunction

    controlador_mult_param #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .strt_cmpt_i  (strt_cmpt_i),
        .state_o      (ctrlState),
        .capture_en_o (captureEn),
        .load_en_o    (loadEn),
        .step_en_o    (stepEn),
        .sign_en_o    (signEn),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .step_o       (step_o)
    );

    // (WIDTH+1)-bit adder: the top bit is the carry c that the shift moves into hi.
    always_comb begin
        partialSum = {1'b0, hi_q};
        if (lo_q[0]) begin
            partialSum = {1'b0, hi_q} + {1'b0, mcand_q};
        end
    end

    assign rawProd = {hi_q, lo_q};

    // Datapath next values: capture operands, load magnitudes, shift-add, apply sign.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        if (captureEn) begin
            a_d    = a_i;
            b_d    = b_i;
            mode_d = mode_i;
        end
        if (loadEn) begin
            mcand_d = magnitude(a_q, mode_q);
            lo_d    = magnitude(b_q, mode_q);
            hi_d    = '0;
            neg_d   = mode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        end
        if (stepEn) begin
            hi_d = partialSum[WIDTH:1];
            lo_d = {partialSum[0], lo_q[WIDTH-1:1]};
        end
        if (signEn) begin
            prod_d = neg_q ? -rawProd : rawProd;
        end
    end

    // Datapath registers; everything clears on reset so no partial result survives.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
        end
    end

    assign prod_o  = prod_q;
    assign state_o = ctrlState;

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Self-checking bench for the parametrised multiplier at WIDTH=4 and WIDTH=8.
module tb_multiplicador_seq_param;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_STEP = 3'd2;
    localparam logic [2:0] S_SIGN = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    typedef struct {
        int          w;
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rstN;

    logic       start4, mode4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] prod4;
    logic [2:0] state4;
    logic [1:0] step4;

    logic        start8, mode8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic [2:0]  state8;
    logic [2:0]  step8;

    int errors;
    int checks;
    logic [31:0] lastProd4, lastProd8;
    vec_t vecs[10];

    multiplicador_seq_param #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rstN), .strt_cmpt_i(start4), .mode_i(mode4),
        .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4),
        .prod_o(prod4), .state_o(state4), .step_o(step4)
    );

    multiplicador_seq_param #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rstN), .strt_cmpt_i(start8), .mode_i(mode8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
        .prod_o(prod8), .state_o(state8), .step_o(step8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [31:0] modelProd(input int w, input logic m,
                                              input logic [15:0] a, input logic [15:0] b);
        longint mask, sa, sb, p;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (m) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    function automatic logic [31:0] getState(input int w);
        return (w == 4) ? 32'(state4) : 32'(state8);
    endfunction

    function automatic logic [31:0] getStep(input int w);
        return (w == 4) ? 32'(step4) : 32'(step8);
    endfunction

    function automatic logic [31:0] getProd(input int w);
        return (w == 4) ? 32'(prod4) : 32'(prod8);
    endfunction

    function automatic logic [31:0] getBusy(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction

    function automatic logic [31:0] getDone(input int w);
        return (w == 4) ? 32'(done4) : 32'(done8);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveOperands(input int w, input logic m, input logic [15:0] a, input logic [15:0] b);
        if (w == 4) begin
            mode4 = m; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            mode8 = m; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic driveStart(input int w, input logic s);
        if (w == 4) start4 = s;
        else        start8 = s;
    endtask

    task automatic checkAll(input string tag, input int w, input logic [2:0] st,
                            input logic bz, input logic dn, input int stp, input logic [31:0] pr);
        checkOutput($sformatf("%s state", tag), getState(w), 32'(st));
        checkOutput($sformatf("%s busy", tag), getBusy(w), 32'(bz));
        checkOutput($sformatf("%s done", tag), getDone(w), 32'(dn));
        checkOutput($sformatf("%s step", tag), getStep(w), 32'(stp));
        checkOutput($sformatf("%s prod", tag), getProd(w), pr);
    endtask

    // One full transaction. dropAt/scrambleAt are the edge index k (E0 = 0) after which
    // start goes low / the operands are overwritten; endHold is extra cycles spent in END.
    task automatic applyStimulus(input string tag, input int w, input logic m,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [31:0] expP, input int dropAt,
                                 input int scrambleAt, input int endHold);
        logic [31:0] prevP;
        logic [2:0]  st;
        bit          startHigh;
        prevP = (w == 4) ? lastProd4 : lastProd8;
        @(negedge clk);
        driveOperands(w, m, a, b);
        driveStart(w, 1'b1);
        startHigh = 1;
        for (int k = 0; k <= w + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0)          st = S_LOAD;
            else if (k <= w)     st = S_STEP;
            else if (k == w + 1) st = S_SIGN;
            else                 st = S_END;
            checkAll($sformatf("%s k=%0d", tag, k), w, st, (k <= w + 1), (k == w + 2),
                     (k >= 1 && k <= w) ? k - 1 : 0, (k <= w + 1) ? prevP : expP);
            if (k == dropAt) begin
                driveStart(w, 1'b0);
                startHigh = 0;
            end
            if (k == scrambleAt) begin
                driveOperands(w, 1'($urandom), 16'($urandom), 16'($urandom));
            end
        end
        if (startHigh) begin
            for (int i = 0; i < endHold; i++) begin
                @(posedge clk);
                @(negedge clk);
                checkAll($sformatf("%s hold%0d", tag, i), w, S_END, 1'b0, 1'b1, 0, expP);
            end
            driveStart(w, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        checkAll($sformatf("%s idle", tag), w, S_IDLE, 1'b0, 1'b0, 0, expP);
        if (w == 4) lastProd4 = expP;
        else        lastProd8 = expP;
    endtask

    // Main sequence: reset, table vectors, handshake corners, mid-run reset, random runs.
    initial begin
        errors = 0;
        checks = 0;
        lastProd4 = '0;
        lastProd8 = '0;
        start4 = 0; mode4 = 0; a4 = '0; b4 = '0;
        start8 = 0; mode8 = 0; a8 = '0; b8 = '0;

        vecs[0] = '{4, 1'b0, 16'd3,    16'd5,    32'd15};
        vecs[1] = '{4, 1'b0, 16'd15,   16'd15,   32'd225};
        vecs[2] = '{4, 1'b1, 16'h8,    16'h8,    32'd64};
        vecs[3] = '{4, 1'b1, 16'hD,    16'd5,    32'hF1};
        vecs[4] = '{4, 1'b1, 16'd0,    16'h9,    32'd0};
        vecs[5] = '{4, 1'b1, 16'hD,    16'hD,    32'd9};
        vecs[6] = '{4, 1'b1, 16'd7,    16'h8,    32'hC8};
        vecs[7] = '{8, 1'b0, 16'd200,  16'd3,    32'd600};
        vecs[8] = '{8, 1'b1, 16'h80,   16'h80,   32'h4000};
        vecs[9] = '{8, 1'b1, 16'hFF,   16'h7F,   32'hFF81};

        rstN = 1'b0;
        #3;
        checkAll("reset w4", 4, S_IDLE, 1'b0, 1'b0, 0, 32'd0);
        checkAll("reset w8", 8, S_IDLE, 1'b0, 1'b0, 0, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].w, vecs[i].m, vecs[i].a, vecs[i].b,
                          vecs[i].exp, 99, -1, 2);
        end

        applyStimulus("hold10", 4, 1'b0, 16'd3, 16'd5, 32'd15, 99, -1, 10);
        applyStimulus("dropE3", 4, 1'b0, 16'd6, 16'd7, 32'd42, 2, -1, 0);
        applyStimulus("aChgE2", 4, 1'b1, 16'hE, 16'd3, 32'hFA, 99, 1, 1);

        @(negedge clk);
        driveOperands(4, 1'b0, 16'd7, 16'd9);
        driveStart(4, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("midrst pre state", 32'(state4), 32'(S_STEP));
        rstN = 1'b0;
        #1;
        checkAll("midrst", 4, S_IDLE, 1'b0, 1'b0, 0, 32'd0);
        driveStart(4, 1'b0);
        lastProd4 = '0;
        lastProd8 = '0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("postrst", 4, 1'b0, 16'd7, 16'd9, 32'd63, 99, -1, 1);

        for (int i = 0; i < 24; i++) begin
            int          w;
            logic        m;
            logic [15:0] a, b;
            int          drop;
            w = (i % 3 == 0) ? 8 : 4;
            m = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            drop = ($urandom_range(0, 1) == 0) ? 99 : int'($urandom_range(0, w + 2));
            applyStimulus($sformatf("rnd%0d", i), w, m, a, b, modelProd(w, m, a, b),
                          drop, -1, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplicador_seq_param.md
Name: multiplicador_seq_param

Overview:
- Parametrised sequential shift-and-add multiplier. It is the successor of the fixed 4-step multiplier controller.
- The operand width is a parameter. The step count follows the width.
- It adds a signed/unsigned mode, a done/busy handshake and an internal product datapath.
- It sits under the top-level multiplier wrapper. It is driven by the same level-sensitive strt_cmpt_i start used by the existing board logic.

Parameters:
- WIDTH, 4, operand width in bits; legal values 2 to 16; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the step counter and of step_o; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- strt_cmpt_i  in  1  level start request.
- mode_i  in  1  0 = unsigned, 1 = two's-complement signed; sampled with the operands.
- a_i  in  WIDTH  multiplicand.
- b_i  in  WIDTH  multiplier.
- busy_o  out  1  high in every state except ST_IDLE and ST_END.
- done_o  out  1  high while in ST_END.
- prod_o  out  2*WIDTH  product register; holds its value until the next load.
- state_o  out  3  current FSM state encoding.
- step_o  out  CNT_W  current iteration index (0 to WIDTH-1).

Behaviour:
- Reset (rst_i low, asynchronous) forces:
  - state ST_IDLE (3'd0), busy_o=0, done_o=0;
  - prod_o=0, step_o=0;
  - all operand and sign registers cleared.
- State encoding: ST_IDLE=0, ST_LOAD=1, ST_STEP=2, ST_SIGN=3, ST_END=4. Codes 5 to 7 go to ST_IDLE on the next edge.
- ST_IDLE:
  - strt_cmpt_i=1 at an edge (call it E0): latch a_i, b_i, mode_i; go to ST_LOAD.
  - Otherwise stay in ST_IDLE.
- ST_LOAD (edge E1):
  - mcand = |a|, mplier = |b| when mode=1, else raw values. Magnitudes are WIDTH-bit unsigned; the most negative value maps to 2^(WIDTH-1) with no overflow.
  - neg = mode & (a_msb ^ b_msb).
  - Accumulator {c, hi, lo} = {0, 0, mplier}; step counter = 0; go to ST_STEP.
- ST_STEP (edges E2 to E(WIDTH+1)), one iteration per edge:
  - If lo[0]=1: {c, hi} = hi + mcand, a (WIDTH+1)-bit sum.
  - Then shift {c, hi, lo} right by 1, with c refilled as 0.
  - Counter increments. After the edge where the counter equals WIDTH-1, go to ST_SIGN.
- ST_SIGN (edge E(WIDTH+2)):
  - prod_o = neg ? -{hi, lo} : {hi, lo}, at 2*WIDTH bits; go to ST_END.
- ST_END:
  - done_o=1.
  - Stay while strt_cmpt_i=1. Go to ST_IDLE on the first edge with strt_cmpt_i=0.
  - If start is already low on entry, done_o is a 1-cycle pulse.
- Latency: done_o rises WIDTH+2 cycles after E0; it is visible after edge E(WIDTH+2).
- strt_cmpt_i changes during ST_LOAD, ST_STEP and ST_SIGN are ignored. A computation always completes.
- Changes on a_i, b_i and mode_i after E0 have no effect until the next start.
- prod_o updates only in ST_SIGN. During ST_STEP it holds the previous result.
- Reset mid-operation aborts immediately: all outputs return to reset values. There is no partial result.
- step_o shows the counter value. It is 0 outside ST_STEP.

Decomposition:
- Shared package in multiplicador_defines.sv:
  - typedef enum logic [2:0] estado_mult_t: ST_IDLE, ST_LOAD, ST_STEP, ST_SIGN, ST_END.
  - localparam MULT_ST_W = 3.
  - It coexists with the existing estado_ram_t.
- Sub-module controlador_mult_param:
  - Contains the FSM and the step counter, parametrised by WIDTH.
  - Outputs: state, load_en, step_en, sign_en.
- The top level holds the datapath: operand and magnitude registers, the (WIDTH+1)-bit adder, the shifter and the negation.

Test Plan:
- WIDTH=4, mode=0, a=3, b=5, start held high:
  - prod_o = 8'd15; done_o rises 6 cycles after E0;
  - state_o sequence 0,1,2,2,2,2,3,4.
- WIDTH=4, mode=0, a=15, b=15 -> prod_o = 8'd225 (max unsigned, exercises the carry bit c).
- WIDTH=4, mode=1, two runs:
  - a=4'b1000, b=4'b1000 -> prod_o = 8'd64;
  - a=4'b1101 (-3), b=5 -> prod_o = 8'hF1 (-15).
- WIDTH=4, mode=1, a=0, b=4'b1001 -> prod_o = 0 (no negative zero).
- Start-handshake run:
  - start held for 10 cycles -> done_o stays 1 until start drops, then ST_IDLE next edge;
  - start dropped at E3 -> computation still completes, done_o pulses 1 cycle.
  - a_i changed at E2 -> no effect on the result.
- Reset and width runs:
  - rst_i low at E3 (ST_STEP) -> busy_o=0, prod_o=0, state_o=0 immediately; a new start gives the correct result.
  - WIDTH=8 regression: 200*-? is not legal unsigned, so use mode=0, 200*3 -> 16'd600; done after 10 cycles.
